conv_window_seq: RTL and testbench

CONV_WINDOW_SEQ -- requirements
Module: conv_window_seq

---
 rtl/conv_pkg.sv | 57 +++++
 rtl/conv_raster_ctr.sv | 50 +++++
 rtl/conv_window_seq.sv | 181 ++++++++++++++++++
 tb/tb_conv_window_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared sizing, types and helpers for the 5x5 convolution window
// sequencer.
//   IMAGE_MAX_W / IMAGE_H : largest supported row width and fixed frame height
//   coord_t               : row/column coordinate (COORD_W bits)
//   kernel_pos_t          : per-neighbour "outside the image" flags
//   state_t               : sequencer FSM states
//   calcPos()             : edge-flag evaluation for one centre coordinate
package conv_pkg;

  localparam int IMAGE_MAX_W  = 1920;
  localparam int IMAGE_H      = 1080;
  localparam int COORD_W      = $clog2(IMAGE_MAX_W);
  localparam int KERNEL_POS_W = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [7:0]         pixel_t;

  // MSB first: west 2/1, east 2/1, north 2/1, south 2/1.
  typedef struct packed {
    logic w2;
    logic w1;
    logic e2;
    logic e1;
    logic n2;
    logic n1;
    logic s2;
    logic s1;
  } kernel_pos_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam coord_t MIN_W    = coord_t'(5);
  localparam coord_t MAX_W    = coord_t'(IMAGE_MAX_W);
  localparam coord_t LAST_ROW = coord_t'(IMAGE_H - 1);

  // A flag is set when that neighbour of (row, col) falls outside the frame.
  // Width is at least 5, so width-3 never underflows.
  function automatic kernel_pos_t calcPos(input coord_t row, input coord_t col,
                                          input coord_t width);
    kernel_pos_t p;
    p.w2 = (col < coord_t'(2));
    p.w1 = (col < coord_t'(1));
    p.e2 = (col > (width - coord_t'(3)));
    p.e1 = (col > (width - coord_t'(2)));
    p.n2 = (row < coord_t'(2));
    p.n1 = (row < coord_t'(1));
    p.s2 = (row > (LAST_ROW - coord_t'(2)));
    p.s1 = (row > (LAST_ROW - coord_t'(1)));
    return p;
  endfunction

endpackage

// File: rtl/conv_raster_ctr.sv
// conv_raster_ctr: raster-order column/row counter.
//   clk, arst_n : clock, asynchronous active-low reset
//   i_clr       : synchronous clear back to (0,0)
//   i_adv       : advance one position in raster order
//   i_width     : row width; column wraps to 0 after i_width-1
//   o_col/o_row : current position
// The row wraps after the last frame row so a counter left running never
// walks outside the frame.
module conv_raster_ctr
  import conv_pkg::*;
(
  input  logic   clk,
  input  logic   arst_n,
  input  logic   i_clr,
  input  logic   i_adv,
  input  coord_t i_width,
  output coord_t o_col,
  output coord_t o_row
);

  coord_t r_col;
  coord_t r_row;
  logic   w_colLast;
  logic   w_rowLast;

  assign w_colLast = (r_col == (i_width - coord_t'(1)));
  assign w_rowLast = (r_row == LAST_ROW);

  // Clear has priority over advance so a new frame always starts at (0,0).
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (w_colLast) begin
        r_col <= '0;
        r_row <= w_rowLast ? '0 : (r_row + coord_t'(1));
      end else begin
        r_col <= r_col + coord_t'(1);
      end
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;

endmodule

// File: rtl/conv_window_seq.sv
// conv_window_seq: sequences a raster pixel stream into 5x5 window centres.
//   clk, arst_n        : clock, asynchronous active-low reset
//   start, cfg_w       : frame start pulse and row width (5..IMAGE_MAX_W)
//   s_valid/s_ready    : input pixel handshake, s_eol marks end of row
//   lb_push, lb_col    : line-buffer write strobe and column of pushed pixel
//   m_valid/m_ready    : centre output handshake
//   m_pos, m_row, m_col: edge flags and coordinates of the current centre
//   busy, done, err    : not-idle, end-of-frame pulse, sticky error
// The first centre needs 2 rows + 2 pixels of look-ahead (L = 2W+2). The L-th
// pixel produces centre (0,0), every later pixel produces the next centre,
// and after the final pixel the remaining centres are drained in FLUSH.
module conv_window_seq
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               arst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_eol,
  output logic               lb_push,
  output logic [COORD_W-1:0] lb_col,
  output logic               m_valid,
  input  logic               m_ready,
  output kernel_pos_t        m_pos,
  output logic [COORD_W-1:0] m_row,
  output logic [COORD_W-1:0] m_col,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t      r_state;
  coord_t      r_width;
  logic        r_mValid;
  kernel_pos_t r_mPos;
  coord_t      r_mRow;
  coord_t      r_mCol;
  logic        r_done;
  logic        r_err;

  logic   w_sReady;
  logic   w_push;
  logic   w_load;
  logic   w_startOk;
  logic   w_fillEnd;
  logic   w_inColLast;
  logic   w_inLast;
  logic   w_mLast;
  coord_t w_inCol;
  coord_t w_inRow;
  coord_t w_ctrCol;
  coord_t w_ctrRow;

  assign w_startOk = (r_state == S_IDLE) && start &&
                     (cfg_w >= MIN_W) && (cfg_w <= MAX_W);

  // Input-side position: column of the pixel currently offered.
  conv_raster_ctr u_inCtr (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_clr   (w_startOk),
    .i_adv   (w_push),
    .i_width (r_width),
    .o_col   (w_inCol),
    .o_row   (w_inRow)
  );

  // Centre-side position: the next centre to be registered on the output.
  conv_raster_ctr u_ctrCtr (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_clr   (w_startOk),
    .i_adv   (w_load),
    .i_width (r_width),
    .o_col   (w_ctrCol),
    .o_row   (w_ctrRow)
  );

  assign w_inColLast = (w_inCol == (r_width - coord_t'(1)));
  assign w_inLast    = w_inColLast && (w_inRow == LAST_ROW);
  // Pixel index 2W+1 (the L-th pixel) sits at row 2, column 1.
  assign w_fillEnd   = (w_inRow == coord_t'(2)) && (w_inCol == coord_t'(1));
  assign w_mLast     = r_mValid && (r_mRow == LAST_ROW) &&
                       (r_mCol == (r_width - coord_t'(1)));

  // Input is only taken while filling, or in RUN when the output slot is
  // empty or being emptied this cycle.
  always_comb begin
    w_sReady = 1'b0;
    case (r_state)
      S_FILL:  w_sReady = 1'b1;
      S_RUN:   w_sReady = ~r_mValid | m_ready;
      default: w_sReady = 1'b0;
    endcase
  end

  assign w_push = s_valid & w_sReady;

  // A new centre is loaded on the closing fill pixel, on every RUN pixel, and
  // in FLUSH whenever the slot frees up until the final centre is out.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      S_FILL:  w_load = w_push & w_fillEnd;
      S_RUN:   w_load = w_push;
      S_FLUSH: w_load = (~r_mValid | m_ready) & ~w_mLast;
      default: w_load = 1'b0;
    endcase
  end

  // Sequencer FSM with registered centre outputs, done pulse and sticky err.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= S_IDLE;
      r_width  <= '0;
      r_mValid <= 1'b0;
      r_mPos   <= '0;
      r_mRow   <= '0;
      r_mCol   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_load) begin
        r_mValid <= 1'b1;
        r_mPos   <= calcPos(w_ctrRow, w_ctrCol, r_width);
        r_mRow   <= w_ctrRow;
        r_mCol   <= w_ctrCol;
      end else if (r_mValid && m_ready) begin
        r_mValid <= 1'b0;
      end

      // Row framing mismatch is flagged but the counters keep going.
      if (w_push && (s_eol != w_inColLast)) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_startOk) begin
              r_width <= cfg_w;
              r_err   <= 1'b0;
              r_state <= S_FILL;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_push && w_fillEnd) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_push && w_inLast) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_mLast && m_ready) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready = w_sReady;
  assign lb_push = w_push;
  assign lb_col  = w_inCol;
  assign m_valid = r_mValid;
  assign m_pos   = r_mPos;
  assign m_row   = r_mRow;
  assign m_col   = r_mCol;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_conv_window_seq.sv
// tb_conv_window_seq: directed bench for conv_window_seq.
// Drives whole frames with a free-running source, watches every handshake at
// the falling edge and compares coordinates, edge flags, counts and flags
// against hand-derived values and a raster-order reference.
module tb_conv_window_seq;

  localparam int FRAME_H = 1080;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] cfg_w = 11'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_eol = 1'b0;
  logic        lb_push;
  logic [10:0] lb_col;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_pos;
  logic [10:0] m_row;
  logic [10:0] m_col;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  // Per-frame observations gathered by the monitor.
  int frameW = 5;
  int inCount, outCount, expRow, expCol, orderErrs, doneCnt, firstAt;
  int firstRow, firstCol, lastRow, lastCol;
  logic [7:0] firstPos, posAt04, posAt22, lastPos;
  logic mValidPrev;

  conv_window_seq dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .start   (start),
    .cfg_w   (cfg_w),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_eol   (s_eol),
    .lb_push (lb_push),
    .lb_col  (lb_col),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_pos   (m_pos),
    .m_row   (m_row),
    .m_col   (m_col),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Reference edge flags for a centre at (row, col) in a frame of width w.
  function automatic logic [7:0] expPos(input int row, input int col, input int w);
    return {col < 2, col < 1, col > w - 3, col > w - 2,
            row < 2, row < 1, row > FRAME_H - 3, row > FRAME_H - 2};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // Sample handshakes half a cycle away from the active edge. A handshake seen
  // here completes on the coming rising edge.
  always @(negedge clk) begin
    if (m_valid && !mValidPrev && firstAt < 0) begin
      firstAt  = inCount;
      firstRow = int'(m_row);
      firstCol = int'(m_col);
      firstPos = m_pos;
    end
    mValidPrev = m_valid;
    if (m_valid && m_ready) begin
      if (int'(m_row) != expRow || int'(m_col) != expCol ||
          m_pos !== expPos(expRow, expCol, frameW))
        orderErrs++;
      if (m_row == 11'd0 && m_col == 11'd4) posAt04 = m_pos;
      if (m_row == 11'd2 && m_col == 11'd2) posAt22 = m_pos;
      lastRow = int'(m_row);
      lastCol = int'(m_col);
      lastPos = m_pos;
      outCount++;
      expCol++;
      if (expCol == frameW) begin
        expCol = 0;
        expRow++;
      end
    end
    if (s_valid && s_ready) inCount++;
    if (done) doneCnt++;
  end

  // Runs one frame of the given width. badEolIdx flips s_eol on that pixel
  // index, stallAfter holds m_ready low for 10 cycles once that many centres
  // are out, busyStartAt pulses an illegal start mid-frame, abortAt resets the
  // block at that cycle. Negative values disable each feature.
  task automatic applyStimulus(input int width, input int badEolIdx,
                               input int stallAfter, input int busyStartAt,
                               input int abortAt);
    int cyc;
    int limit;
    bit stallDone;
    int readyErrs, holdErrs;
    logic [10:0] snapRow, snapCol;
    logic [7:0] snapPos;
    frameW = width;
    inCount = 0; outCount = 0; expRow = 0; expCol = 0; orderErrs = 0;
    doneCnt = 0; firstAt = -1; mValidPrev = 1'b0;
    stallDone = 1'b0;
    limit = 2 * width * FRAME_H + 200;
    @(posedge clk); #1;
    cfg_w = 11'(width); start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (doneCnt == 0 && cyc < limit) begin
      if (abortAt >= 0 && cyc == abortAt) begin
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        arst_n = 1'b0;
        #1;
        checkOutput("rst_flags", 32'({s_ready, m_valid, lb_push, busy, done, err}), 32'd0);
        checkOutput("rst_mrow", 32'(m_row), 32'd0);
        checkOutput("rst_mcol", 32'(m_col), 32'd0);
        checkOutput("rst_mpos", 32'(m_pos), 32'd0);
        checkOutput("rst_lbcol", 32'(lb_col), 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        return;
      end
      if (stallAfter >= 0 && !stallDone && outCount >= stallAfter) begin
        stallDone = 1'b1;
        start = 1'b0;
        snapRow = m_row; snapCol = m_col; snapPos = m_pos;
        m_ready = 1'b0;
        readyErrs = 0; holdErrs = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (s_ready !== 1'b0 || lb_push !== 1'b0) readyErrs++;
          if (m_valid !== 1'b1 || m_row !== snapRow || m_col !== snapCol ||
              m_pos !== snapPos) holdErrs++;
        end
        checkOutput("stall_sready", 32'(readyErrs), 32'd0);
        checkOutput("stall_hold", 32'(holdErrs), 32'd0);
        @(posedge clk); #1;
        cyc += 10;
      end
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_eol = (((inCount % width) == width - 1) != (inCount == badEolIdx));
      start = (cyc == busyStartAt);
      cfg_w = (cyc == busyStartAt) ? 11'd4 : 11'(width);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    checkOutput("frame_done", 32'(doneCnt > 0), 32'd1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    #2 arst_n = 1'b0;
    #1;
    checkOutput("reset_flags", 32'({s_ready, m_valid, lb_push, busy, done, err}), 32'd0);
    checkOutput("reset_coord", 32'({m_row, m_col}), 32'd0);
    checkOutput("reset_pos", 32'(m_pos), 32'd0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;

    // W=5 frame with a mid-frame stall and an ignored start while busy.
    $display("[TB] frame W=5");
    applyStimulus(5, -1, 100, 60, -1);
    checkOutput("w5_first_at", 32'(firstAt), 32'd12);
    checkOutput("w5_first_row", 32'(firstRow), 32'd0);
    checkOutput("w5_first_col", 32'(firstCol), 32'd0);
    checkOutput("w5_first_pos", 32'(firstPos), 32'hCC);
    checkOutput("w5_pos_0_4", 32'(posAt04), 32'h3C);
    checkOutput("w5_pos_2_2", 32'(posAt22), 32'h00);
    checkOutput("w5_last_row", 32'(lastRow), 32'd1079);
    checkOutput("w5_last_col", 32'(lastCol), 32'd4);
    checkOutput("w5_last_pos", 32'(lastPos), 32'h33);
    checkOutput("w5_outputs", 32'(outCount), 32'd5400);
    checkOutput("w5_inputs", 32'(inCount), 32'd5400);
    checkOutput("w5_order", 32'(orderErrs), 32'd0);
    checkOutput("w5_done_cnt", 32'(doneCnt), 32'd1);
    checkOutput("w5_err", 32'(err), 32'd0);
    checkOutput("w5_idle", 32'(busy), 32'd0);

    // Illegal width is refused.
    @(posedge clk); #1;
    cfg_w = 11'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("w4_err", 32'(err), 32'd1);
    checkOutput("w4_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("w4_still_idle", 32'(busy), 32'd0);

    // W=8 frame with s_eol wrongly raised at column 2 of row 0.
    $display("[TB] frame W=8");
    applyStimulus(8, 2, -1, -1, -1);
    checkOutput("w8_err", 32'(err), 32'd1);
    checkOutput("w8_outputs", 32'(outCount), 32'd8640);
    checkOutput("w8_inputs", 32'(inCount), 32'd8640);
    checkOutput("w8_order", 32'(orderErrs), 32'd0);
    checkOutput("w8_done_cnt", 32'(doneCnt), 32'd1);

    // Reset mid-RUN, then a clean W=6 frame.
    $display("[TB] abort then frame W=6");
    applyStimulus(5, -1, -1, -1, 40);
    applyStimulus(6, -1, -1, -1, -1);
    checkOutput("w6_first_at", 32'(firstAt), 32'd14);
    checkOutput("w6_first_pos", 32'(firstPos), 32'hCC);
    checkOutput("w6_outputs", 32'(outCount), 32'd6480);
    checkOutput("w6_order", 32'(orderErrs), 32'd0);
    checkOutput("w6_done_cnt", 32'(doneCnt), 32'd1);
    checkOutput("w6_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
